// File: rtl/regfile_mp.sv
// regfile_mp: dual-read / dual-write register file with a clear sequencer.
//
// The design has two combinational read ports with write-to-read bypass and
// two write ports. When both write ports target the same address, port 1
// wins. With ZERO_REG=1, register 0 reads as zero and discards writes.
//
// A two-state sequencer (IDLE/SWEEP) zeroes one entry per cycle so that a
// context can be flushed without asserting reset. While the sweep runs,
// both write ports are dropped and bypass is disabled. SeqState exposes the
// sequencer state for debug.
//
// Optional build macro REGFILE_SCOREBOARD_EN adds a per-register
// pending-bit scoreboard, with ports PendSet/PendAddr/Pend1/Pend2.
//
// ClearReq is a level request with no ready handshake. It is sampled only
// in IDLE, and a request seen on a clk edge in IDLE starts exactly one
// sweep. While the sweep runs, ClearReq is ignored and nothing is queued.
// ClearBusy is the busy indication.

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              WriteEn0,
  input  logic [ADDR_W-1:0] WriteRegister0,
  input  logic [DATA_W-1:0] WriteData0,
  input  logic              WriteEn1,
  input  logic [ADDR_W-1:0] WriteRegister1,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic              ClearReq,
  output logic              ClearBusy,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic              PendSet,
  input  logic [ADDR_W-1:0] PendAddr,
  output logic              Pend1,
  output logic              Pend2,
`endif
  output logic              SeqState
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic busy;
  logic zero_en;
  logic wr0_ok, wr1_ok;

  assign busy      = (state_q == S_SWEEP);
  assign ClearBusy = busy;
  assign SeqState  = state_q;
  assign zero_en   = (ZERO_REG != 0);

  // A write commits only when the sweep is idle. With ZERO_REG=1, a write
  // to register 0 never commits.
  assign wr0_ok = WriteEn0 && !busy && !(zero_en && (WriteRegister0 == '0));
  assign wr1_ok = WriteEn1 && !busy && !(zero_en && (WriteRegister1 == '0));

  // Sequencer state and sweep index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sequencer next state. The sweep ends on the edge that clears the last
  // entry, and the index is parked at 0 instead of wrapping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (ClearReq) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end
      end
      S_SWEEP: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Storage next state: the sweep zeroes entry idx, otherwise port 1 is
  // applied after port 0 so that port 1 wins on an address collision.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (busy) begin
        if (idx_q == ADDR_W'(i)) mem_d[i] = '0;
      end else begin
        if (wr0_ok && (WriteRegister0 == ADDR_W'(i))) mem_d[i] = WriteData0;
        if (wr1_ok && (WriteRegister1 == ADDR_W'(i))) mem_d[i] = WriteData1;
      end
    end
  end

  // Storage registers; reset clears every entry asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Read port A: zero register, then bypass from port 1, then bypass from
  // port 0, then the stored value. Bypass is suppressed during the sweep
  // because the writes it would forward are dropped.
  always_comb begin
    ReadData1 = mem_q[ReadRegister1];
    if (reset) begin
      ReadData1 = '0;
    end else if (zero_en && (ReadRegister1 == '0)) begin
      ReadData1 = '0;
    end else if (WriteEn1 && (WriteRegister1 == ReadRegister1) && !busy) begin
      ReadData1 = WriteData1;
    end else if (WriteEn0 && (WriteRegister0 == ReadRegister1) && !busy) begin
      ReadData1 = WriteData0;
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    ReadData2 = mem_q[ReadRegister2];
    if (reset) begin
      ReadData2 = '0;
    end else if (zero_en && (ReadRegister2 == '0)) begin
      ReadData2 = '0;
    end else if (WriteEn1 && (WriteRegister1 == ReadRegister2) && !busy) begin
      ReadData2 = WriteData1;
    end else if (WriteEn0 && (WriteRegister0 == ReadRegister2) && !busy) begin
      ReadData2 = WriteData0;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pend_q, pend_d;
  logic             set_ok;

  assign set_ok = PendSet && !(zero_en && (PendAddr == '0));

  // Pending-bit next state. A committed write clears the bit, a set on the
  // same address in the same cycle overrides that clear, and the sweep
  // clears each bit together with its data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      pend_d[i] = pend_q[i];
      if (wr0_ok && (WriteRegister0 == ADDR_W'(i))) pend_d[i] = 1'b0;
      if (wr1_ok && (WriteRegister1 == ADDR_W'(i))) pend_d[i] = 1'b0;
      if (set_ok && (PendAddr == ADDR_W'(i)))       pend_d[i] = 1'b1;
      if (busy && (idx_q == ADDR_W'(i)))            pend_d[i] = 1'b0;
    end
  end

  // Pending-bit registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // Pending status lookup for both read addresses.
  always_comb begin
    Pend1 = pend_q[ReadRegister1];
    Pend2 = pend_q[ReadRegister2];
    if (zero_en && (ReadRegister1 == '0)) Pend1 = 1'b0;
    if (zero_en && (ReadRegister2 == '0)) Pend2 = 1'b0;
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table plus hand-written sequences for
// reset, the clear sweep, reset in the middle of a sweep, and the optional
// scoreboard.

module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] ra1, ra2, wa0, wa1;
  logic [DW-1:0] rd1, rd2, wd0, wd1;
  logic          we0, we1, clr_req, clr_busy, seq_state;
`ifdef REGFILE_SCOREBOARD_EN
  logic          pend_set, pend1, pend2;
  logic [AW-1:0] pend_addr;
`endif

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .ReadRegister1  (ra1),
    .ReadRegister2  (ra2),
    .ReadData1      (rd1),
    .ReadData2      (rd2),
    .WriteEn0       (we0),
    .WriteRegister0 (wa0),
    .WriteData0     (wd0),
    .WriteEn1       (we1),
    .WriteRegister1 (wa1),
    .WriteData1     (wd1),
    .ClearReq       (clr_req),
    .ClearBusy      (clr_busy),
`ifdef REGFILE_SCOREBOARD_EN
    .PendSet        (pend_set),
    .PendAddr       (pend_addr),
    .Pend1          (pend1),
    .Pend2          (pend2),
`endif
    .SeqState       (seq_state)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    ra1 = '0; ra2 = '0; clr_req = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
    pend_set = 1'b0; pend_addr = '0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive_idle();
    we0 = 1'b1; wa0 = a; wd0 = d;
    tick();
    drive_idle();
  endtask

  task automatic write1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive_idle();
    we1 = 1'b1; wa1 = a; wd1 = d;
    tick();
    drive_idle();
  endtask

  // Both ports read each address; the expected value comes from exp_q.
  task automatic readback(input string name, input int lo, input int hi);
    logic [DW-1:0] e;
    for (int a = lo; a <= hi; a++) begin
      ra1 = AW'(a); ra2 = AW'(a);
      #1;
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL %s: expected queue empty at addr %0d", name, a);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s rd1[%0d]", name, a), rd1, e);
        check($sformatf("%s rd2[%0d]", name, a), rd2, e);
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  vec_t vecs[13];
  int   n;

  initial begin
    // Each row: inputs applied, read outputs checked combinationally, then
    // one clock edge commits the writes.
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd1,  32'h0,        32'h0};
    vecs[1]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  32'h22,       5'd7,  5'd7,  32'h22,       32'h22};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd3,  32'h22,       32'hDEADBEEF};
    vecs[5]  = '{1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h66,       5'd0,  5'd7,  32'h0,        32'h22};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h22};
    vecs[8]  = '{1'b1, 5'd10, 32'hA,        1'b1, 5'd11, 32'hB,        5'd10, 5'd11, 32'hA,        32'hB};
    vecs[9]  = '{1'b1, 5'd3,  32'h123,      1'b0, 5'd0,  32'h0,        5'd3,  5'd10, 32'h123,      32'hA};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd11, 32'h123,      32'hB};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd31, 5'd10, 32'hFFFFFFFF, 32'hA};

    // ---------- reset state ----------
    drive_idle();
    ra1 = 5'd3; ra2 = 5'd31;
    #2;
    check("rd1 in reset", rd1, '0);
    check("busy in reset", {31'b0, clr_busy}, '0);
    tick();
    #3 reset = 1'b0;
    tick();
    drive_idle();
    check("busy after reset", {31'b0, clr_busy}, '0);
    for (int a = 0; a < 32; a++) exp_q.push_back('0);
    readback("post-reset", 0, 31);

    // ---------- directed vectors ----------
    for (int v = 0; v < 13; v++) begin
      drive_idle();
      we0 = vecs[v].we0; wa0 = vecs[v].wa0; wd0 = vecs[v].wd0;
      we1 = vecs[v].we1; wa1 = vecs[v].wa1; wd1 = vecs[v].wd1;
      ra1 = vecs[v].ra1; ra2 = vecs[v].ra2;
      #1;
      check($sformatf("vec%0d rd1", v), rd1, vecs[v].exp1);
      check($sformatf("vec%0d rd2", v), rd2, vecs[v].exp2);
      tick();
    end
    drive_idle();

    // ---------- fill 1..31 with index, then sweep ----------
    for (int a = 1; a < 32; a++) begin
      if (a % 2 == 0) write0(AW'(a), DW'(a));
      else            write1(AW'(a), DW'(a));
    end
    for (int a = 0; a < 32; a++) exp_q.push_back(DW'(a));
    readback("fill", 0, 31);

    // A write in the same cycle that ClearReq is sampled is committed.
    drive_idle();
    clr_req = 1'b1; we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h77;
    #1;
    check("busy before sweep", {31'b0, clr_busy}, '0);
    tick();
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      drive_idle();
      if (n == 1) begin
        ra1 = 5'd2;
        #1 check("sweep reg2 committed", rd1, 32'h77);
      end
      if (n == 10) begin
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h99;
        ra1 = 5'd5; ra2 = 5'd20;
        #1;
        check("sweep no bypass", rd1, 32'h0);
        check("sweep partial", rd2, 32'd20);
      end
      if (n == 15) clr_req = 1'b1;
      tick();
      n++;
    end
    drive_idle();
    check("sweep length", DW'(n), 32'd32);
    check("idle after sweep", {31'b0, seq_state}, '0);
    for (int a = 0; a < 32; a++) exp_q.push_back('0);
    readback("post-sweep", 0, 31);

    // ---------- reset in the middle of a sweep ----------
    for (int a = 20; a < 32; a++) write0(AW'(a), 32'h100 + DW'(a));
    exp_q.push_back(32'h119);
    readback("pre-reset reg25", 25, 25);
    drive_idle();
    clr_req = 1'b1;
    tick();
    drive_idle();
    for (int c = 0; c < 10; c++) tick();
    check("busy at sweep cycle 10", {31'b0, clr_busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("busy falls on async reset", {31'b0, clr_busy}, '0);
    ra1 = 5'd25;
    #0 check("rd1 during reset", rd1, '0);
    #1 reset = 1'b0;
    tick();
    check("idle after mid-sweep reset", {31'b0, clr_busy}, '0);
    for (int a = 20; a < 32; a++) exp_q.push_back('0);
    readback("post-reset sweep", 20, 31);

`ifdef REGFILE_SCOREBOARD_EN
    // ---------- pending-bit scoreboard ----------
    drive_idle();
    pend_set = 1'b1; pend_addr = 5'd4;
    tick();
    drive_idle();
    ra1 = 5'd4; ra2 = 5'd5;
    #1;
    check("pend1 set", {31'b0, pend1}, 32'h1);
    check("pend2 other", {31'b0, pend2}, '0);
    drive_idle();
    pend_set = 1'b1; pend_addr = 5'd4; we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h4;
    tick();
    drive_idle();
    ra1 = 5'd4;
    #1 check("pend set wins", {31'b0, pend1}, 32'h1);
    write0(5'd4, 32'h44);
    ra1 = 5'd4;
    #1 check("pend cleared by write", {31'b0, pend1}, '0);
    drive_idle();
    pend_set = 1'b1; pend_addr = 5'd0;
    tick();
    drive_idle();
    #1 check("pend zero reg", {31'b0, pend1}, '0);
`endif

    // ---------- final report ----------
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised, multi-port successor to the pipeline register file. It provides two combinational read ports with write-to-read bypass and two write ports with defined collision priority. It also has a multi-cycle clear sequencer for soft context flush without asserting reset. It sits in the decode stage of a dual-issue MIPS pipeline.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes; when 0 it is an ordinary register

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
ReadRegister1  input  ADDR_W  read port A address
ReadRegister2  input  ADDR_W  read port B address
ReadData1  output  DATA_W  read port A data
ReadData2  output  DATA_W  read port B data
WriteEn0  input  1  write port 0 enable
WriteRegister0  input  ADDR_W  write port 0 address
WriteData0  input  DATA_W  write port 0 data
WriteEn1  input  1  write port 1 enable
WriteRegister1  input  ADDR_W  write port 1 address
WriteData1  input  DATA_W  write port 1 data
ClearReq  input  1  request a sequenced clear of all registers
ClearBusy  output  1  clear sequence in progress

Behaviour:
- Reset (asynchronous, active-high):
  - all DEPTH entries are set to 0.
  - the sequencer enters IDLE; ClearBusy = 0.
  - while reset is asserted, ReadData1/2 = 0.
- Writes: take effect at the rising clk edge.
  - When both ports are enabled to the same address, port 1 wins.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Reads: combinational, zero latency. Each read port applies, in priority order:
  1. ZERO_REG=1 and address 0 -> 0.
  2. WriteEn1 && WriteRegister1 == addr && !ClearBusy -> WriteData1.
  3. WriteEn0 && WriteRegister0 == addr && !ClearBusy -> WriteData0.
  4. Otherwise the stored value.
- Clear sequencer FSM: IDLE, SWEEP.
  - IDLE -> SWEEP: on a clk edge with ClearReq = 1. The index counter loads 0.
  - SWEEP: each cycle writes 0 to entry[idx], then idx increments.
  - SWEEP -> IDLE: on the edge that clears entry DEPTH-1. The index does not wrap.
  - ClearBusy = 1 exactly in SWEEP, i.e. for DEPTH cycles starting the cycle after ClearReq is sampled.
  - ClearReq is ignored while in SWEEP; there is no queuing or restart.
  - Both write ports are dropped while ClearBusy = 1, and bypass is disabled.
  - Reads during SWEEP return the partially-cleared contents.
  - A write presented in the same cycle ClearReq is sampled in IDLE is committed. The sweep later zeroes it.
- Reset asserted mid-SWEEP: immediate return to IDLE and all entries are 0.

Optional Feature:
REGFILE_SCOREBOARD_EN
- Defined: adds a per-register pending-bit scoreboard and the following ports:
  - PendSet (input, 1), PendAddr (input, ADDR_W): mark a register as awaiting a write.
  - Pend1, Pend2 (output, 1): pending status for ReadRegister1 and ReadRegister2.
- Pending-bit rules:
  - PendSet && PendAddr != 0 (when ZERO_REG=1) sets the bit at the clk edge.
  - A committed write from either port clears the bit for its address.
  - When set and clear hit the same address in the same cycle, set wins.
  - SWEEP clears each pending bit alongside its data.
  - Reset clears all pending bits.
  - Pend1/Pend2 are combinational and are forced to 0 for address 0 when ZERO_REG=1.
- Undefined: no scoreboard logic and none of these ports exist.

Test Plan:
- Reset release, then read all addresses on both ports -> every ReadData = 0; ClearBusy = 0.
- WriteEn0, addr 3, data 0xDEADBEEF; same cycle read addr 3 -> ReadData1 = 0xDEADBEEF (bypass). Next cycle with write idle -> still 0xDEADBEEF.
- Both ports write addr 7: port 0 data 0x11, port 1 data 0x22 -> bypass and stored value are both 0x22. Write addr 0 with 0x55 -> reads 0.
- Fill regs 1..31 with their index; pulse ClearReq -> ClearBusy high for 32 cycles. A write of 0x99 to reg 5 mid-sweep is dropped. After the sweep, all regs read 0.
- Assert reset asynchronously at sweep cycle 10 with regs 20..31 holding nonzero values -> ClearBusy falls without waiting for clk; all reads = 0.
- With REGFILE_SCOREBOARD_EN: PendSet addr 4 -> Pend1 = 1 on addr 4. WriteEn1 addr 4 in the same cycle as PendSet addr 4 -> Pend stays 1. A later write to addr 4 -> Pend1 = 0.
